// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: drives an external single-round key_gen
// datapath for NR rounds, stores every round key, and serves them through a
// registered read port.
module aes_key_sched_ctrl #(
    parameter  int unsigned NR     = 10,
    localparam int unsigned KEY_W  = 128,
    localparam int unsigned RCON_W = 32,
    localparam int unsigned RND_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KEY_W-1:0]  key_in,
    output logic              busy,
    output logic              done,
    output logic              keys_valid,
    output logic [KEY_W-1:0]  kg_key,
    output logic [KEY_W-1:0]  kg_mx_key,
    output logic [RCON_W-1:0] kg_rcon,
    input  logic [KEY_W-1:0]  kg_rkey,
    input  logic [RND_W-1:0]  rd_idx,
    output logic [KEY_W-1:0]  rd_key
);

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NR);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [RND_W-1:0]    rnd_q, rnd_d;
    logic [KEY_W-1:0]    kg_key_q, kg_key_d;
    logic [KEY_W-1:0]    mx_key_q, mx_key_d;
    logic [RCON_W-1:0]   rcon_q, rcon_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                kv_q, kv_d;
    logic [KEY_W-1:0]    rd_key_q;
    logic [KEY_W-1:0]    store_q [NR+1];

    logic                accept;
    logic                capture;

    // Round constant for a given round number; zero outside 1..10.
    function automatic logic [7:0] rcon_byte(input logic [RND_W-1:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign accept  = (state_q == S_IDLE) && start;
    assign capture = (state_q == S_EXPAND);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one capture per cycle until the last round is stored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_EXPAND;
            S_EXPAND: if (rnd_q == LAST_RND) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values; flags follow the state being entered.
    always_comb begin
        rnd_d    = rnd_q;
        kg_key_d = kg_key_q;
        mx_key_d = mx_key_q;
        kv_d     = kv_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        rcon_d   = '0;

        if (accept) begin
            rnd_d    = RND_W'(1);
            kg_key_d = key_in;
            mx_key_d = key_in;
            kv_d     = 1'b0;
        end

        if (capture) begin
            kg_key_d = kg_rkey;
            rnd_d    = (rnd_q == LAST_RND) ? '0 : rnd_q + RND_W'(1);
        end

        if (state_d == S_DONE) begin
            done_d = 1'b1;
            kv_d   = 1'b1;
        end

        busy_d = (state_d == S_EXPAND);
        if (busy_d) begin
            rcon_d = {rcon_byte(rnd_d), 24'h0};
        end
    end

    // Registered outputs, round counter and read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rnd_q    <= '0;
            kg_key_q <= '0;
            mx_key_q <= '0;
            rcon_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            kv_q     <= 1'b0;
            rd_key_q <= '0;
        end else begin
            rnd_q    <= rnd_d;
            kg_key_q <= kg_key_d;
            mx_key_q <= mx_key_d;
            rcon_q   <= rcon_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            kv_q     <= kv_d;
            rd_key_q <= (rd_idx <= LAST_RND) ? store_q[rd_idx] : '0;
        end
    end

    // Round-key store; contents are left as-is on reset, keys_valid guards them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept) begin
                store_q[0] <= key_in;
            end else if (capture) begin
                store_q[rnd_q] <= kg_rkey;
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = kv_q;
    assign kg_key     = kg_key_q;
    assign kg_mx_key  = mx_key_q;
    assign kg_rcon    = rcon_q;
    assign rd_key     = rd_key_q;

endmodule
